// File: rtl/i2c_master_tx.sv
// i2c_master_tx: single-transaction I2C write master.
// Sends a 12-bit word as three bytes to one slave and reports NACKs.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [6:0]  SLAVE_ADDR = 7'd52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_A,
    S_START_B,
    S_BIT,
    S_ACK,
    S_STOP
  } state_e;

  localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [11:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_low_q, sda_low_d;
  logic        sda_s1_q, sda_s2_q;
  logic        tick;
  logic [7:0]  cur_byte;
  logic        bit_val;

  assign tick = (qcnt_q == QMAX);

  function automatic logic [7:0] byte_sel(
    input logic [1:0]  idx,
    input logic [11:0] d
  );
    case (idx)
      2'd0:    byte_sel = {SLAVE_ADDR, 1'b0};
      2'd1:    byte_sel = d[11:4];
      default: byte_sel = {d[3:0], 4'b0000};
    endcase
  endfunction

  // Next-state logic: quarter timebase, bit/byte sequencing, ACK decision
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    data_d    = data_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    qcnt_d    = (state_q == S_IDLE || tick) ? '0 : qcnt_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START_A;
          data_d    = tx_data;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          qtr_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
        end
      end
      S_START_A: if (tick) state_d = S_START_B;
      S_START_B: if (tick) state_d = S_BIT;
      S_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (sda_s2_q) begin
              ack_err_d = 1'b1;
              state_d   = S_STOP;
            end else if (byte_q == 2'd2) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = S_BIT;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            state_d = S_IDLE;
            qtr_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels for the upcoming cycle, registered so SCL/SDA never glitch
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    cur_byte  = byte_sel(byte_d, data_d);
    bit_val   = cur_byte[3'd7 - bit_d];
    unique case (state_d)
      S_START_B: sda_low_d = 1'b1;
      S_BIT: begin
        scl_d     = qtr_d[1];
        sda_low_d = ~bit_val;
      end
      S_ACK: scl_d = qtr_d[1];
      S_STOP: begin
        scl_d     = (qtr_d != 2'd0);
        sda_low_d = (qtr_d != 2'd2);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // State, counters, outputs and the SDA synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      sda_s1_q  <= sda;
      sda_s2_q  <= sda_s1_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl     = scl_q;
  assign sda     = sda_low_q ? 1'b0 : 1'bz;

endmodule
